adc_dual_capture: RTL and testbench

//  Conversion controller for the board's dual-channel SAR ADC (CNVST/BUSY/CS/SCLK, DoutA/DoutB serial outputs).

---
 rtl/adc_dual_capture_pkg.sv | 37 +++
 rtl/adc_dual_capture_sync.sv | 26 ++
 rtl/adc_dual_capture.sv | 204 ++++++++++++++++++++
 tb/tb_adc_dual_capture.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_dual_capture_pkg.sv
// Shared definitions for the dual-channel SAR ADC capture controller.
// Contents:
//   state_e      - conversion FSM states
//   DEF_*        - default timing parameters, shared with sibling pin controllers
//   timer_width  - width of the shared cycle timer (at least 8 bits)
package adc_dual_capture_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StConv,
        StWaitHi,
        StWaitLo,
        StRead,
        StDone,
        StAbort
    } state_e;

    localparam int unsigned DEF_DATA_BITS = 12;
    localparam int unsigned DEF_SCLK_DIV  = 4;
    localparam int unsigned DEF_CNV_LOW   = 2;
    localparam int unsigned DEF_BUSY_TO   = 255;
    localparam int unsigned DEF_AVG_LOG2  = 2;

    // One timer serves the CNVST pulse, the BUSY timeouts and the SCLK half-periods.
    function automatic int unsigned timer_width(input int unsigned busy_to,
                                                input int unsigned cnv_low,
                                                input int unsigned sclk_div);
        int unsigned m;
        int unsigned w;
        m = busy_to;
        if (cnv_low > m) m = cnv_low;
        if (sclk_div > m) m = sclk_div;
        w = $clog2(m + 1);
        return (w < 8) ? 8 : w;
    endfunction

endpackage

// File: rtl/adc_dual_capture_sync.sv
// Two-flop synchronizer for a single asynchronous level.
// Ports:
//   clk - destination clock
//   rst - async active-high reset, output clears to 0
//   d   - asynchronous input
//   q   - synchronized output (two clk cycles of latency)
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/adc_dual_capture.sv
// Conversion controller for a dual-channel SAR ADC. One start request runs a
// conversion (CNVST pulse, BUSY handshake) and shifts both channels in MSB-first,
// then presents data_a/data_b with a one-cycle valid pulse. A BUSY edge that
// never arrives aborts the conversion with a one-cycle err pulse.
// Build option: define ADC_AVG_EN to average 2**AVG_LOG2 conversions per start.
// Ports:
//   CLK, RST          - system clock, async active-high reset
//   start             - one-cycle request, ignored while busy
//   busy              - high from accepted start until valid/err
//   valid, err        - one-cycle completion / timeout pulses
//   data_a, data_b    - channel results, held until the next valid
//   CNVST_ADC, CS_ADC - active-low convert start and chip select
//   SCLK_ADC          - serial clock, idles high
//   BUSY_ADC          - ADC busy (asynchronous)
//   DoutA_ADC/B       - serial data from the ADC
module adc_dual_capture
    import adc_dual_capture_pkg::*;
#(
    parameter int unsigned DATA_BITS = DEF_DATA_BITS,
    parameter int unsigned SCLK_DIV  = DEF_SCLK_DIV,
    parameter int unsigned CNV_LOW   = DEF_CNV_LOW,
    parameter int unsigned BUSY_TO   = DEF_BUSY_TO,
    parameter int unsigned AVG_LOG2  = DEF_AVG_LOG2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    output logic                 busy,
    output logic                 valid,
    output logic [DATA_BITS-1:0] data_a,
    output logic [DATA_BITS-1:0] data_b,
    output logic                 err,
    output logic                 CNVST_ADC,
    output logic                 CS_ADC,
    output logic                 SCLK_ADC,
    input  logic                 BUSY_ADC,
    input  logic                 DoutA_ADC,
    input  logic                 DoutB_ADC
);

    localparam int unsigned TW = timer_width(BUSY_TO, CNV_LOW, SCLK_DIV);
    localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] CNV_RELOAD  = TW'(CNV_LOW - 1);
    localparam logic [TW-1:0] BUSY_RELOAD = TW'(BUSY_TO - 1);
    localparam logic [TW-1:0] HALF_RELOAD = TW'(SCLK_DIV - 1);
    localparam logic [BW-1:0] LAST_BIT    = BW'(DATA_BITS - 1);

    logic                 busy_s;
    state_e               state;
    logic [TW-1:0]        tmr;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] sh_a;
    logic [DATA_BITS-1:0] sh_b;

    sync_2ff u_busy_sync (
        .clk (CLK),
        .rst (RST),
        .d   (BUSY_ADC),
        .q   (busy_s)
    );

`ifdef ADC_AVG_EN
    localparam int unsigned AW = DATA_BITS + AVG_LOG2;

    logic [AW-1:0]       acc_a;
    logic [AW-1:0]       acc_b;
    logic [AW-1:0]       sum_a;
    logic [AW-1:0]       sum_b;
    logic [AVG_LOG2-1:0] conv_idx;

    // Running sum including the word that has just finished shifting in.
    assign sum_a = acc_a + AW'(sh_a);
    assign sum_b = acc_b + AW'(sh_b);
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= StIdle;
            tmr       <= '0;
            bit_cnt   <= '0;
            sh_a      <= '0;
            sh_b      <= '0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            err       <= 1'b0;
            data_a    <= '0;
            data_b    <= '0;
            CNVST_ADC <= 1'b1;
            CS_ADC    <= 1'b1;
            SCLK_ADC  <= 1'b1;
`ifdef ADC_AVG_EN
            acc_a     <= '0;
            acc_b     <= '0;
            conv_idx  <= '0;
`endif
        end else begin
            valid <= 1'b0;
            err   <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state     <= StConv;
                        busy      <= 1'b1;
                        CNVST_ADC <= 1'b0;
                        tmr       <= CNV_RELOAD;
`ifdef ADC_AVG_EN
                        acc_a     <= '0;
                        acc_b     <= '0;
                        conv_idx  <= '0;
`endif
                    end
                end
                StConv: begin
                    if (tmr == '0) begin
                        state     <= StWaitHi;
                        CNVST_ADC <= 1'b1;
                        tmr       <= BUSY_RELOAD;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                StWaitHi: begin
                    if (busy_s) begin
                        state <= StWaitLo;
                        tmr   <= BUSY_RELOAD;
                    end else if (tmr == '0) begin
                        state     <= StAbort;
                        err       <= 1'b1;
                        busy      <= 1'b0;
                        CNVST_ADC <= 1'b1;
                        CS_ADC    <= 1'b1;
                        SCLK_ADC  <= 1'b1;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                StWaitLo: begin
                    if (!busy_s) begin
                        // First SCLK fall coincides with CS assertion.
                        state    <= StRead;
                        CS_ADC   <= 1'b0;
                        SCLK_ADC <= 1'b0;
                        tmr      <= HALF_RELOAD;
                        bit_cnt  <= '0;
                    end else if (tmr == '0) begin
                        state     <= StAbort;
                        err       <= 1'b1;
                        busy      <= 1'b0;
                        CNVST_ADC <= 1'b1;
                        CS_ADC    <= 1'b1;
                        SCLK_ADC  <= 1'b1;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                StRead: begin
                    if (tmr != '0) begin
                        tmr <= tmr - 1'b1;
                    end else if (!SCLK_ADC) begin
                        // Sample on the edge that raises SCLK.
                        SCLK_ADC <= 1'b1;
                        sh_a     <= {sh_a[DATA_BITS-2:0], DoutA_ADC};
                        sh_b     <= {sh_b[DATA_BITS-2:0], DoutB_ADC};
                        tmr      <= HALF_RELOAD;
                    end else if (bit_cnt != LAST_BIT) begin
                        SCLK_ADC <= 1'b0;
                        bit_cnt  <= bit_cnt + 1'b1;
                        tmr      <= HALF_RELOAD;
                    end else begin
                        CS_ADC <= 1'b1;
`ifdef ADC_AVG_EN
                        if (conv_idx != '1) begin
                            // Chain the next conversion of the batch directly.
                            acc_a     <= sum_a;
                            acc_b     <= sum_b;
                            conv_idx  <= conv_idx + 1'b1;
                            state     <= StConv;
                            CNVST_ADC <= 1'b0;
                            tmr       <= CNV_RELOAD;
                        end else begin
                            data_a <= DATA_BITS'(sum_a >> AVG_LOG2);
                            data_b <= DATA_BITS'(sum_b >> AVG_LOG2);
                            valid  <= 1'b1;
                            busy   <= 1'b0;
                            state  <= StDone;
                        end
`else
                        data_a <= sh_a;
                        data_b <= sh_b;
                        valid  <= 1'b1;
                        busy   <= 1'b0;
                        state  <= StDone;
`endif
                    end
                end
                StDone: state <= StIdle;
                StAbort: state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_dual_capture.sv
module tb_adc_dual_capture;

    localparam int DATA_BITS = 12;
    localparam int SCLK_DIV  = 4;
    localparam int CNV_LOW   = 2;
    localparam int BUSY_TO   = 255;
    localparam int AVG_LOG2  = 2;
`ifdef ADC_AVG_EN
    localparam int N = 1 << AVG_LOG2;
`else
    localparam int N = 1;
`endif

    logic                 CLK = 1'b0;
    logic                 RST = 1'b1;
    logic                 start = 1'b0;
    logic                 busy, valid, err;
    logic [DATA_BITS-1:0] data_a, data_b;
    logic                 CNVST_ADC, CS_ADC, SCLK_ADC;
    logic                 BUSY_ADC = 1'b0;
    logic                 DoutA_ADC = 1'b0;
    logic                 DoutB_ADC = 1'b0;

    adc_dual_capture #(
        .DATA_BITS (DATA_BITS),
        .SCLK_DIV  (SCLK_DIV),
        .CNV_LOW   (CNV_LOW),
        .BUSY_TO   (BUSY_TO),
        .AVG_LOG2  (AVG_LOG2)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .busy      (busy),
        .valid     (valid),
        .data_a    (data_a),
        .data_b    (data_b),
        .err       (err),
        .CNVST_ADC (CNVST_ADC),
        .CS_ADC    (CS_ADC),
        .SCLK_ADC  (SCLK_ADC),
        .BUSY_ADC  (BUSY_ADC),
        .DoutA_ADC (DoutA_ADC),
        .DoutB_ADC (DoutB_ADC)
    );

    always #5 CLK = ~CLK;

    // ADC pin model: BUSY pulse after each CNVST fall, data bit after each SCLK fall.
    logic [DATA_BITS-1:0] q_a[$];
    logic [DATA_BITS-1:0] q_b[$];
    logic [DATA_BITS-1:0] cur_a = '0;
    logic [DATA_BITS-1:0] cur_b = '0;
    int  bit_idx = DATA_BITS - 1;
    bit  busy_en = 1'b1;

    int  n_tests = 0;
    int  n_fail = 0;
    int  sclk_rises = 0;
    int  cnv_pulses = 0;
    int  cnv_low_cyc = 0;
    bit  cs_low_seen = 1'b0;
    int  sum_a = 0;
    int  sum_b = 0;

    always @(negedge CNVST_ADC) begin
        if (q_a.size() > 0) begin
            cur_a = q_a.pop_front();
            cur_b = q_b.pop_front();
        end else begin
            cur_a = '0;
            cur_b = '0;
        end
        bit_idx = DATA_BITS - 1;
        cnv_pulses++;
        if (busy_en) begin
            #40 BUSY_ADC = 1'b1;
            #700 BUSY_ADC = 1'b0;
        end
    end

    always @(negedge SCLK_ADC) begin
        #20;
        DoutA_ADC = cur_a[bit_idx];
        DoutB_ADC = cur_b[bit_idx];
        if (bit_idx > 0) bit_idx--;
    end

    always @(posedge SCLK_ADC) sclk_rises++;

    always @(negedge CLK) begin
        if (CNVST_ADC === 1'b0) cnv_low_cyc++;
        if (CS_ADC === 1'b0) cs_low_seen = 1'b1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [DATA_BITS-1:0] a, input logic [DATA_BITS-1:0] b);
        q_a.push_back(a);
        q_b.push_back(b);
        sum_a += int'(a);
        sum_b += int'(b);
    endtask

    task automatic clear_counts();
        sclk_rises  = 0;
        cnv_pulses  = 0;
        cnv_low_cyc = 0;
        cs_low_seen = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    // Waits at negedges for valid or err; optionally re-pulses start at given cycles.
    task automatic wait_done(input int budget, input int extra1, input int extra2,
                             output bit got_valid, output bit got_err, output int lat,
                             output bit busy_drop);
        got_valid = 1'b0;
        got_err   = 1'b0;
        lat       = 0;
        busy_drop = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (valid === 1'b1) begin
                got_valid = 1'b1;
                lat = i;
                break;
            end
            if (err === 1'b1) begin
                got_err = 1'b1;
                lat = i;
                break;
            end
            if (busy !== 1'b1) busy_drop = 1'b1;
            @(negedge CLK);
            start = ((i + 1) == extra1) || ((i + 1) == extra2);
        end
        start = 1'b0;
        check("completion_within_budget", {31'b0, got_valid | got_err}, 32'd1);
    endtask

    // Full batch with freshly pushed words; checks data against the batch average.
    task automatic run_batch(input string tag);
        bit gv, ge, bd;
        int lat;
        pulse_start();
        wait_done(4000, -1, -1, gv, ge, lat, bd);
        check({tag, "_valid"}, {31'b0, gv}, 32'd1);
        check({tag, "_data_a"}, 32'(data_a), 32'(sum_a / N));
        check({tag, "_data_b"}, 32'(data_b), 32'(sum_b / N));
    endtask

    initial begin
        bit gv, ge, bd;
        int lat;
        int base;
        int extra_valids;
        int exp1_a, exp1_b, exp2_a, exp2_b;
        logic [DATA_BITS-1:0] prev_a, prev_b;

        // Reset state
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_cnvst", {31'b0, CNVST_ADC}, 32'd1);
        check("rst_cs", {31'b0, CS_ADC}, 32'd1);
        check("rst_sclk", {31'b0, SCLK_ADC}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_valid", {31'b0, valid}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_data_a", 32'(data_a), 32'd0);
        check("rst_data_b", 32'(data_b), 32'd0);
        RST = 1'b0;
        @(negedge CLK);

        // 1: fixed words
        sum_a = 0; sum_b = 0;
        for (int k = 0; k < N; k++) push_word(12'hA5C, 12'h3F0);
        clear_counts();
        run_batch("t1");
        check("t1_sclk_rises", 32'(sclk_rises), 32'(DATA_BITS * N));
        check("t1_cnvst_low_cycles", 32'(cnv_low_cyc), 32'(CNV_LOW * N));
        check("t1_cnvst_pulses", 32'(cnv_pulses), 32'(N));

        // 2: BUSY never rises -> timeout
        repeat (5) @(negedge CLK);
        busy_en = 1'b0;
        prev_a = data_a;
        prev_b = data_b;
        clear_counts();
        pulse_start();
        wait_done(600, -1, -1, gv, ge, lat, bd);
        check("t2_err", {31'b0, ge}, 32'd1);
        check("t2_no_valid", {31'b0, gv}, 32'd0);
        check("t2_err_latency", {31'b0, (lat >= CNV_LOW + BUSY_TO) && (lat <= CNV_LOW + BUSY_TO + 3)},
              32'd1);
        check("t2_data_a_held", 32'(data_a), 32'(prev_a));
        check("t2_data_b_held", 32'(data_b), 32'(prev_b));
        check("t2_cs_never_low", {31'b0, cs_low_seen}, 32'd0);
        @(negedge CLK);
        check("t2_pins_idle", {29'b0, CNVST_ADC, CS_ADC, SCLK_ADC}, 32'd7);
        check("t2_busy_low", {31'b0, busy}, 32'd0);
        busy_en = 1'b1;

        // 3: extra starts in WAIT_LO and READ are dropped
        repeat (5) @(negedge CLK);
        sum_a = 0; sum_b = 0;
        for (int k = 0; k < N; k++) push_word(DATA_BITS'($urandom_range(0, 4095)),
                                              DATA_BITS'($urandom_range(0, 4095)));
        clear_counts();
        pulse_start();
        wait_done(4000, 30, 120, gv, ge, lat, bd);
        check("t3_valid", {31'b0, gv}, 32'd1);
        check("t3_busy_held", {31'b0, bd}, 32'd0);
        check("t3_data_a", 32'(data_a), 32'(sum_a / N));
        check("t3_data_b", 32'(data_b), 32'(sum_b / N));
        extra_valids = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (valid === 1'b1) extra_valids++;
        end
        check("t3_no_second_valid", 32'(extra_valids), 32'd0);
        check("t3_cnvst_pulses", 32'(cnv_pulses), 32'(N));

        // 4: reset after the 5th SCLK rise
        sum_a = 0; sum_b = 0;
        for (int k = 0; k < N; k++) push_word(12'h123, 12'hFED);
        clear_counts();
        pulse_start();
        base = 0;
        for (int i = 0; i < 1000; i++) begin
            if (sclk_rises >= 5) break;
            @(negedge CLK);
            base = i;
        end
        check("t4_reached_5_rises", {31'b0, sclk_rises >= 5}, 32'd1);
        RST = 1'b1;
        #1;
        check("t4_pins_idle", {29'b0, CNVST_ADC, CS_ADC, SCLK_ADC}, 32'd7);
        check("t4_data_a_zero", 32'(data_a), 32'd0);
        check("t4_data_b_zero", 32'(data_b), 32'd0);
        check("t4_busy_zero", {31'b0, busy}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        q_a.delete();
        q_b.delete();
        repeat (5) @(negedge CLK);
        sum_a = 0; sum_b = 0;
        for (int k = 0; k < N; k++) push_word(DATA_BITS'($urandom_range(0, 4095)),
                                              DATA_BITS'($urandom_range(0, 4095)));
        run_batch("t4_after");

`ifdef ADC_AVG_EN
        // 5: averaging with truncation
        repeat (5) @(negedge CLK);
        sum_a = 0; sum_b = 0;
        push_word(12'd100, 12'd7);
        push_word(12'd102, 12'd8);
        push_word(12'd104, 12'd8);
        push_word(12'd106, 12'd8);
        clear_counts();
        pulse_start();
        wait_done(4000, -1, -1, gv, ge, lat, bd);
        check("t5_valid", {31'b0, gv}, 32'd1);
        check("t5_data_a", 32'(data_a), 32'd103);
        check("t5_data_b", 32'(data_b), 32'd7);
        check("t5_cnvst_pulses", 32'(cnv_pulses), 32'd4);
`endif

        // 6: back-to-back, start in the cycle after valid
        repeat (5) @(negedge CLK);
        sum_a = 0; sum_b = 0;
        for (int k = 0; k < N; k++) push_word(DATA_BITS'($urandom_range(0, 4095)),
                                              DATA_BITS'($urandom_range(0, 4095)));
        exp1_a = sum_a / N;
        exp1_b = sum_b / N;
        sum_a = 0; sum_b = 0;
        for (int k = 0; k < N; k++) push_word(DATA_BITS'($urandom_range(0, 4095)),
                                              DATA_BITS'($urandom_range(0, 4095)));
        exp2_a = sum_a / N;
        exp2_b = sum_b / N;
        clear_counts();
        pulse_start();
        wait_done(4000, -1, -1, gv, ge, lat, bd);
        check("t6_first_valid", {31'b0, gv}, 32'd1);
        check("t6_first_data_a", 32'(data_a), 32'(exp1_a));
        check("t6_first_data_b", 32'(data_b), 32'(exp1_b));
        @(negedge CLK);
        check("t6_pins_idle_between", {29'b0, CNVST_ADC, CS_ADC, SCLK_ADC}, 32'd7);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        wait_done(4000, -1, -1, gv, ge, lat, bd);
        check("t6_second_valid", {31'b0, gv}, 32'd1);
        check("t6_second_data_a", 32'(data_a), 32'(exp2_a));
        check("t6_second_data_b", 32'(data_b), 32'(exp2_b));
        check("t6_cnvst_pulses", 32'(cnv_pulses), 32'(2 * N));

        // Random words
        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(1, 6)) @(negedge CLK);
            sum_a = 0; sum_b = 0;
            for (int k = 0; k < N; k++) push_word(DATA_BITS'($urandom_range(0, 4095)),
                                                  DATA_BITS'($urandom_range(0, 4095)));
            run_batch("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
